// File: rtl/multu_hilo.sv
// Sequential unsigned WIDTHxWIDTH shift-add multiplier with a HI/LO register pair.
// The product reaches HI/LO only on the commit strobe; MFHI/MFLO reads are combinational.
module multu_hilo #(
  parameter int          WIDTH        = 32,
  parameter logic [5:0]  MULTU_CODE   = 6'b011001,
  parameter logic [5:0]  HILO_WR_CODE = 6'b111111,
  parameter logic [5:0]  MFHI_CODE    = 6'b010000,
  parameter logic [5:0]  MFLO_CODE    = 6'b010010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [5:0] LAST_ITER = 6'(WIDTH);

  state_t               state, state_n;
  logic [2*WIDTH-1:0]   mcand, mcand_n;
  logic [2*WIDTH-1:0]   product, product_n;
  logic [WIDTH-1:0]     mplier, mplier_n;
  logic [WIDTH-1:0]     hi, hi_n, lo, lo_n;
  logic [5:0]           iter, iter_n;
  logic                 err_q, err_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      product <= '0;
      mplier  <= '0;
      hi      <= '0;
      lo      <= '0;
      iter    <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      mcand   <= mcand_n;
      product <= product_n;
      mplier  <= mplier_n;
      hi      <= hi_n;
      lo      <= lo_n;
      iter    <= iter_n;
      err_q   <= err_n;
    end
  end

  // Signal protocol: MULTU must be held every cycle of the multiply; the
  // commit strobe is only legal in DONE, anywhere else it pulses err.
  always_comb begin
    state_n   = state;
    mcand_n   = mcand;
    product_n = product;
    mplier_n  = mplier;
    hi_n      = hi;
    lo_n      = lo;
    iter_n    = iter;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        if (Signal == MULTU_CODE) begin
          // This edge already performs iteration 0 on the fresh operands.
          mcand_n   = {{WIDTH{1'b0}}, dataA} << 1;
          mplier_n  = dataB >> 1;
          product_n = dataB[0] ? {{WIDTH{1'b0}}, dataA} : '0;
          iter_n    = 6'd1;
          state_n   = BUSY;
        end else if (Signal == HILO_WR_CODE) begin
          err_n = 1'b1;
        end
      end
      BUSY: begin
        if (Signal == MULTU_CODE) begin
          product_n = product + (mplier[0] ? mcand : '0);
          mcand_n   = mcand << 1;
          mplier_n  = mplier >> 1;
          iter_n    = iter + 6'd1;
          if (iter_n == LAST_ITER) state_n = DONE;
        end else begin
          err_n   = (Signal == HILO_WR_CODE);
          state_n = IDLE;
        end
      end
      DONE: begin
        if (Signal == HILO_WR_CODE) begin
          hi_n    = product[2*WIDTH-1:WIDTH];
          lo_n    = product[WIDTH-1:0];
          state_n = IDLE;
        end else if (Signal != MULTU_CODE) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);
  assign err  = err_q;

  always_comb begin
    dataOut = '0;
    if (Signal == MFHI_CODE)      dataOut = hi;
    else if (Signal == MFLO_CODE) dataOut = lo;
  end

endmodule
